// File: rtl/lcd_ctrl_pkg.sv
// Shared encodings and constants for the LCD sequencing controller.
package lcd_ctrl_pkg;

    // Top-level sequencing states
    typedef enum logic [2:0] {
        TOP_PWRUP = 3'd0,
        TOP_INIT  = 3'd1,
        TOP_IDLE  = 3'd2,
        TOP_ADDR  = 3'd3,
        TOP_DIGIT = 3'd4
    } top_state_e;

    // Phases of a single LCD transfer
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SETUP  = 3'd1,
        PH_STROBE = 3'd2,
        PH_HOLD   = 3'd3,
        PH_WAIT   = 3'd4
    } phase_e;

    // Fixed DDRAM address command and digit character prefix used by the datapath
    localparam logic [7:0] ADDR_CMD     = 8'hCE;
    localparam logic [3:0] DIGIT_PREFIX = 4'b0011;

    // Last index of both the init sequence and the digit sequence
    localparam logic [1:0] LAST_IDX = 2'd3;

    // Larger of two cycle counts
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold max_val (never narrower than one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Bundle between the sequencing controller and the LCD datapath / pins.
interface lcd_ctrl_if;
    logic       update;
    logic [1:0] init_sel;
    logic [1:0] mux_sel;
    logic       data_sel;
    logic       DB_sel;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       ready;

    // Controller side
    modport master (
        input  update,
        output init_sel, mux_sel, data_sel, DB_sel, lcd_rs, lcd_rw, lcd_e, ready
    );

    // Top-level / datapath side
    modport slave (
        output update,
        input  init_sel, mux_sel, data_sel, DB_sel, lcd_rs, lcd_rw, lcd_e, ready
    );
endinterface

// File: rtl/lcd_strobe.sv
// Transfer phase engine: SETUP -> STROBE (E high) -> HOLD -> WAIT, one shared down-counter.
module lcd_strobe
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EPULSE_CYC     = 4,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned CMD_WAIT_CYC   = 10,
    parameter int unsigned CLEAR_WAIT_CYC = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_wait_long,
    output logic o_lcd_e,
    output logic o_done_c
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, EPULSE_CYC), HOLD_CYC),
                                            max_u(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
    localparam int unsigned CNT_W   = cnt_width(MAX_CYC);

    phase_e           r_phase;
    phase_e           w_phase_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_wait_long;
    logic             w_wait_long_nxt;
    logic             r_e;
    logic             w_done_c;

    // Last WAIT cycle; a new start here chains straight into the next SETUP
    assign w_done_c = (r_phase == PH_WAIT) && (r_cnt == '0);
    assign o_done_c = w_done_c;
    assign o_lcd_e  = r_e;

    // Phase register, counter and E strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= PH_IDLE;
            r_cnt       <= '0;
            r_wait_long <= 1'b0;
            r_e         <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wait_long <= w_wait_long_nxt;
            r_e         <= (w_phase_nxt == PH_STROBE);
        end
    end

    // Phase sequencing; counter holds remaining cycles minus one
    always_comb begin
        w_phase_nxt     = r_phase;
        w_cnt_nxt       = r_cnt;
        w_wait_long_nxt = r_wait_long;

        unique case (r_phase)
            PH_IDLE: begin
            end
            PH_SETUP: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_STROBE;
                    w_cnt_nxt   = CNT_W'(EPULSE_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            PH_STROBE: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_HOLD;
                    w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            PH_HOLD: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_WAIT;
                    w_cnt_nxt   = r_wait_long ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                              : CNT_W'(CMD_WAIT_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            PH_WAIT: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
            end
        endcase

        if (i_start && ((r_phase == PH_IDLE) || w_done_c)) begin
            w_phase_nxt     = PH_SETUP;
            w_cnt_nxt       = CNT_W'(SETUP_CYC - 1);
            w_wait_long_nxt = i_wait_long;
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD sequencing controller: power-up wait, init commands, periodic/requested display refresh.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 20,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EPULSE_CYC     = 4,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned CMD_WAIT_CYC   = 10,
    parameter int unsigned CLEAR_WAIT_CYC = 30,
    parameter int unsigned CLEAR_SEL      = 2,
    parameter int unsigned REFRESH_CYC    = 200
) (
    input  logic       clk,
    input  logic       reset,
    lcd_ctrl_if.master bus
);

    localparam int unsigned TMR_W = cnt_width(max_u(POWERUP_CYC, REFRESH_CYC));

    top_state_e       r_state;
    top_state_e       w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_pending;
    logic             w_pending_nxt;
    logic [1:0]       r_init_sel;
    logic [1:0]       w_init_sel_nxt;
    logic [1:0]       r_mux_sel;
    logic [1:0]       w_mux_sel_nxt;
    logic             r_data_sel;
    logic             w_data_sel_nxt;
    logic             r_db_sel;
    logic             w_db_sel_nxt;
    logic             r_rs;
    logic             w_rs_nxt;
    logic             r_ready;
    logic             w_load_init;
    logic             w_load_addr;
    logic             w_load_digit;
    logic             w_start;
    logic             w_wait_long;
    logic             w_done_c;
    logic             w_lcd_e;

    lcd_strobe #(
        .SETUP_CYC      (SETUP_CYC),
        .EPULSE_CYC     (EPULSE_CYC),
        .HOLD_CYC       (HOLD_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_strobe (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_wait_long (w_wait_long),
        .o_lcd_e     (w_lcd_e),
        .o_done_c    (w_done_c)
    );

    assign bus.init_sel = r_init_sel;
    assign bus.mux_sel  = r_mux_sel;
    assign bus.data_sel = r_data_sel;
    assign bus.DB_sel   = r_db_sel;
    assign bus.lcd_rs   = r_rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = w_lcd_e;
    assign bus.ready    = r_ready;

    // Top state, sequence index, timer, pending request and select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TOP_PWRUP;
            r_idx      <= '0;
            r_timer    <= '0;
            r_pending  <= 1'b0;
            r_init_sel <= '0;
            r_mux_sel  <= '0;
            r_data_sel <= 1'b0;
            r_db_sel   <= 1'b1;
            r_rs       <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_init_sel <= w_init_sel_nxt;
            r_mux_sel  <= w_mux_sel_nxt;
            r_data_sel <= w_data_sel_nxt;
            r_db_sel   <= w_db_sel_nxt;
            r_rs       <= w_rs_nxt;
            r_ready    <= (w_state_nxt == TOP_IDLE);
        end
    end

    // Sequencing decisions; selects are only loaded together with a transfer start
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_timer_nxt    = r_timer;
        w_pending_nxt  = r_pending | bus.update;
        w_init_sel_nxt = r_init_sel;
        w_mux_sel_nxt  = r_mux_sel;
        w_data_sel_nxt = r_data_sel;
        w_db_sel_nxt   = r_db_sel;
        w_rs_nxt       = r_rs;
        w_load_init    = 1'b0;
        w_load_addr    = 1'b0;
        w_load_digit   = 1'b0;
        w_start        = 1'b0;
        w_wait_long    = 1'b0;

        unique case (r_state)
            TOP_PWRUP: begin
                if (r_timer == TMR_W'(POWERUP_CYC - 1)) begin
                    w_state_nxt = TOP_INIT;
                    w_idx_nxt   = '0;
                    w_load_init = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            TOP_INIT: begin
                if (w_done_c) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = TOP_ADDR;
                        w_load_addr = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_load_init = 1'b1;
                    end
                end
            end
            TOP_ADDR: begin
                if (w_done_c) begin
                    w_state_nxt  = TOP_DIGIT;
                    w_idx_nxt    = '0;
                    w_load_digit = 1'b1;
                end
            end
            TOP_DIGIT: begin
                if (w_done_c) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = TOP_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_idx_nxt    = r_idx + 2'd1;
                        w_load_digit = 1'b1;
                    end
                end
            end
            TOP_IDLE: begin
                if (r_pending || bus.update || (r_timer == TMR_W'(REFRESH_CYC - 1))) begin
                    w_state_nxt   = TOP_ADDR;
                    w_timer_nxt   = '0;
                    w_pending_nxt = 1'b0;
                    w_load_addr   = 1'b1;
                end else begin
                    w_timer_nxt   = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = TOP_PWRUP;
                w_timer_nxt = '0;
            end
        endcase

        if (w_load_init) begin
            w_start        = 1'b1;
            w_wait_long    = (w_idx_nxt == 2'(CLEAR_SEL));
            w_init_sel_nxt = w_idx_nxt;
            w_data_sel_nxt = 1'b0;
            w_db_sel_nxt   = 1'b1;
            w_rs_nxt       = 1'b0;
        end
        if (w_load_addr) begin
            w_start        = 1'b1;
            w_db_sel_nxt   = 1'b0;
            w_rs_nxt       = 1'b0;
        end
        if (w_load_digit) begin
            // Digits go out most significant first: count3 .. count0
            w_start        = 1'b1;
            w_mux_sel_nxt  = ~w_idx_nxt;
            w_data_sel_nxt = 1'b1;
            w_db_sel_nxt   = 1'b1;
            w_rs_nxt       = 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: timeline model of expected strobes and ready edges.
module tb_lcd_ctrl;
    import lcd_ctrl_pkg::*;

    localparam int unsigned T_PWR    = 20;
    localparam int unsigned T_SETUP  = 2;
    localparam int unsigned T_EPULSE = 4;
    localparam int unsigned T_HOLD   = 2;
    localparam int unsigned T_CMDW   = 10;
    localparam int unsigned T_CLRW   = 30;
    localparam int unsigned T_REFR   = 200;
    localparam int          XFER     = 2 + 4 + 2 + 10;

    localparam logic [7:0] INIT_CMD [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    typedef struct {
        int         rise;
        logic [7:0] db;
        logic       rs;
    } xfer_t;

    typedef struct {
        int   cyc;
        logic val;
    } rdy_t;

    logic       clk;
    logic       reset;
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic [3:0] count [4];
    logic [7:0] w_db;
    xfer_t      exp_q [$];
    rdy_t       rdy_q [$];

    lcd_ctrl_if bus ();

    lcd_ctrl #(
        .POWERUP_CYC    (T_PWR),
        .SETUP_CYC      (T_SETUP),
        .EPULSE_CYC     (T_EPULSE),
        .HOLD_CYC       (T_HOLD),
        .CMD_WAIT_CYC   (T_CMDW),
        .CLEAR_WAIT_CYC (T_CLRW),
        .CLEAR_SEL      (2),
        .REFRESH_CYC    (T_REFR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Datapath model: DB bus as the external muxes would produce it
    always_comb begin
        if (!bus.DB_sel)      w_db = ADDR_CMD;
        else if (bus.data_sel) w_db = {DIGIT_PREFIX, count[bus.mux_sel]};
        else                  w_db = INIT_CMD[bus.init_sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_init_sel"}, 32'(bus.init_sel), 0);
        check({tag, "_mux_sel"},  32'(bus.mux_sel),  0);
        check({tag, "_data_sel"}, 32'(bus.data_sel), 0);
        check({tag, "_DB_sel"},   32'(bus.DB_sel),   1);
        check({tag, "_rs"},       32'(bus.lcd_rs),   0);
        check({tag, "_rw"},       32'(bus.lcd_rw),   0);
        check({tag, "_e"},        32'(bus.lcd_e),    0);
        check({tag, "_ready"},    32'(bus.ready),    0);
    endtask

    // Monitor: pops an expectation at every E rise and every ready edge
    logic       m_prev_e;
    logic       m_prev_ready;
    int         m_width;
    logic [7:0] m_db;
    logic       m_rs;
    always @(negedge clk) begin
        xfer_t t;
        rdy_t  r;
        if (reset) begin
            m_prev_e     = 1'b0;
            m_prev_ready = 1'b0;
            m_width      = 0;
        end else begin
            if (bus.lcd_e && !m_prev_e) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: E rose at cycle %0d with no transfer expected", cyc);
                end else begin
                    t = exp_q.pop_front();
                    check("rise_cycle", cyc, t.rise);
                    check("db", 32'(w_db), 32'(t.db));
                    check("rs", 32'(bus.lcd_rs), 32'(t.rs));
                    check("rw", 32'(bus.lcd_rw), 0);
                    check("ready_during_xfer", 32'(bus.ready), 0);
                end
                m_width = 1;
                m_db    = w_db;
                m_rs    = bus.lcd_rs;
            end else if (bus.lcd_e) begin
                m_width++;
                check("db_stable", 32'(w_db), 32'(m_db));
                check("rs_stable", 32'(bus.lcd_rs), 32'(m_rs));
            end else if (m_prev_e) begin
                check("e_width", m_width, T_EPULSE);
            end
            if (bus.ready !== m_prev_ready) begin
                if (rdy_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: ready became %0b at cycle %0d", bus.ready, cyc);
                end else begin
                    r = rdy_q.pop_front();
                    check("ready_edge_cycle", cyc, r.cyc);
                    check("ready_edge_value", 32'(bus.ready), 32'(r.val));
                end
            end
            m_prev_e     = bus.lcd_e;
            m_prev_ready = bus.ready;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Update held high for exactly cycle c
    task automatic pulse_update(input int c);
        wait_cyc(c);
        bus.update = 1'b1;
        @(posedge clk);
        #1;
        bus.update = 1'b0;
    endtask

    // Init: four commands starting after power-up; returns first ADDR start cycle
    task automatic push_init(output int s_end);
        xfer_t t;
        int    s;
        s = T_PWR;
        for (int i = 0; i < 4; i++) begin
            t.rise = s + T_SETUP;
            t.db   = INIT_CMD[i];
            t.rs   = 1'b0;
            exp_q.push_back(t);
            s += T_SETUP + T_EPULSE + T_HOLD + ((i == 2) ? T_CLRW : T_CMDW);
        end
        s_end = s;
    endtask

    // Refresh starting at cycle s: address then count3..count0; returns ready-rise cycle
    task automatic push_refresh(input int s_in, input bit after_init, output int e);
        xfer_t t;
        rdy_t  r;
        int    s;
        s = s_in;
        if (!after_init) begin
            r.cyc = s;
            r.val = 1'b0;
            rdy_q.push_back(r);
        end
        t.rise = s + T_SETUP;
        t.db   = 8'hCE;
        t.rs   = 1'b0;
        exp_q.push_back(t);
        s += XFER;
        for (int i = 3; i >= 0; i--) begin
            t.rise = s + T_SETUP;
            t.db   = 8'h30 | {4'h0, count[i]};
            t.rs   = 1'b1;
            exp_q.push_back(t);
            s += XFER;
        end
        r.cyc = s;
        r.val = 1'b1;
        rdy_q.push_back(r);
        e = s;
    endtask

    task automatic randomize_counts();
        for (int i = 0; i < 4; i++) count[i] = 4'($urandom_range(0, 9));
    endtask

    // One run from reset release: init, then n_ep refreshes under mixed update traffic
    task automatic run_phase(input bit upd_in_init, input int n_ep, output int nxt);
        int mode;
        int s;
        int e;
        int k;
        int u1;
        int u2;
        bit pend;
        int modes [5];
        modes = '{0, 1, 2, 0, 1};
        push_init(s);
        pend = 1'b0;
        if (upd_in_init) begin
            pulse_update(50);
            pend = 1'b1;
        end
        for (int ep = 0; ep < n_ep; ep++) begin
            if (ep == 0 && !upd_in_init) begin
                count[3] = 4'd1; count[2] = 4'd2; count[1] = 4'd3; count[0] = 4'd4;
            end else begin
                randomize_counts();
            end
            push_refresh(s, ep == 0, e);
            mode = (ep < 5) ? modes[ep] : int'($urandom_range(0, 2));
            if (mode == 2) begin
                u1 = int'($urandom_range(s + XFER, s + 5 * XFER - 10));
                u2 = int'($urandom_range(u1 + 1, s + 5 * XFER - 1));
                pulse_update(u1);
                pulse_update(u2);
                pend = 1'b1;
            end
            wait_cyc(e);
            if (pend) begin
                s    = e + 1;
                pend = 1'b0;
            end else if (mode == 1) begin
                k = (ep == 1) ? 0 : (ep == 4) ? int'(T_REFR) - 1 : int'($urandom_range(0, T_REFR - 1));
                pulse_update(e + k);
                s = e + k + 1;
            end else begin
                s = e + T_REFR;
            end
        end
        nxt = s;
    endtask

    // Stimulus
    initial begin
        int s;
        int e;
        n_tests    = 0;
        n_fail     = 0;
        bus.update = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < 4; i++) count[i] = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        reset = 1'b0;

        run_phase(1'b0, 8, s);

        // Reset in the middle of an E pulse
        randomize_counts();
        push_refresh(s, 1'b0, e);
        wait_cyc(s + int'(T_SETUP) + 1);
        check("e_high_before_reset", 32'(bus.lcd_e), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rdy_q.delete();
        reset = 1'b0;

        run_phase(1'b1, 7, s);
        randomize_counts();
        push_refresh(s, 1'b0, e);
        wait_cyc(e + 3);

        check("strobes_outstanding", 32'(exp_q.size()), 0);
        check("ready_edges_outstanding", 32'(rdy_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
